// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 geometry) and display mode enumeration.
// Imported by vga_axis_cnt and vga_timing_gen.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 32'd640;
  localparam int unsigned VGA_H_FRONT  = 32'd16;
  localparam int unsigned VGA_H_SYNC   = 32'd96;
  localparam int unsigned VGA_H_BACK   = 32'd48;
  localparam int unsigned VGA_V_ACTIVE = 32'd480;
  localparam int unsigned VGA_V_FRONT  = 32'd10;
  localparam int unsigned VGA_V_SYNC   = 32'd2;
  localparam int unsigned VGA_V_BACK   = 32'd33;
  localparam int unsigned VGA_CW       = 32'd11;
  localparam int unsigned VGA_CLK_DIV  = 32'd4;

  typedef enum logic [1:0] {
    MODE_640X480   = 2'd0,
    MODE_800X600   = 2'd1,
    MODE_1024X768  = 2'd2,
    MODE_1280X1024 = 2'd3
  } vga_mode_e;

  function automatic int unsigned axis_total(input int unsigned act, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return act + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping counter with sync decode registered from the next count,
// plus combinational wrap and next-active flags for the parent to combine.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FRONT  = VGA_H_FRONT,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BACK   = VGA_H_BACK,
  parameter logic        POL    = 1'b0,
  parameter int unsigned CW     = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          sync,
  output logic          act_nxt,
  output logic          wrap
);

  localparam int unsigned   TOTAL    = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] SYNC_LO  = CW'(ACTIVE + FRONT);
  localparam logic [CW-1:0] SYNC_HI  = CW'(ACTIVE + FRONT + SYNC);
  localparam logic [CW-1:0] ACT_HI   = CW'(ACTIVE);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          sync_r;
  logic          sync_nxt_s;
  logic          at_last_s;

  // Next count and sync level, so the registered sync lines up with the registered count.
  always_comb begin
    at_last_s  = (cnt_r == CNT_LAST);
    cnt_nxt_s  = cnt_r;
    sync_nxt_s = ~POL;
    if (en) begin
      if (at_last_s) begin
        cnt_nxt_s = {CW{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
    if ((cnt_nxt_s >= SYNC_LO) && (cnt_nxt_s < SYNC_HI)) begin
      sync_nxt_s = POL;
    end else begin
      sync_nxt_s = ~POL;
    end
  end

  // Counter and sync state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      sync_r <= ~POL;
    end else begin
      cnt_r  <= cnt_nxt_s;
      sync_r <= sync_nxt_s;
    end
  end

  assign cnt     = cnt_r;
  assign sync    = sync_r;
  assign act_nxt = (cnt_nxt_s < ACT_HI);
  assign wrap    = en & at_last_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync strobes, active flag, start pulses.
// Optional macro VGA_TIMING_CLKDIV_EN replaces PIX_CE with an internal divide-by-CLK_DIV enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = VGA_H_FRONT,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BACK   = VGA_H_BACK,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = VGA_V_FRONT,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BACK   = VGA_V_BACK,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CW       = VGA_CW,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  output logic [CW-1:0] x_pix,
  output logic [CW-1:0] y_pix,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL   = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL   = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if ((CW < 32'd32) && ((64'd1 << CW) <= 64'(MAX_TOTAL))) begin : g_cw_too_small
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 32'd1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic pix_en_s;
  logic h_wrap_s;
  logic v_wrap_s;
  logic h_act_nxt_s;
  logic v_act_nxt_s;
  logic active_r;
  logic line_start_r;
  logic frame_start_r;

`ifdef VGA_TIMING_CLKDIV_EN
  localparam int unsigned    DIV_W    = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);

  logic [DIV_W-1:0] div_r;

  // Modulo-CLK_DIV divider; the enable fires on its last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DIV_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  assign pix_en_s = (div_r == DIV_LAST);
`else
  assign pix_en_s = pix_ce;
`endif

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (H_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pix_en_s),
    .cnt     (x_pix),
    .sync    (hsync),
    .act_nxt (h_act_nxt_s),
    .wrap    (h_wrap_s)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (V_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (h_wrap_s),
    .cnt     (y_pix),
    .sync    (vsync),
    .act_nxt (v_act_nxt_s),
    .wrap    (v_wrap_s)
  );

  // Active flag and start pulses registered alongside the counters; a wrap shows as a pulse at count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r      <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      active_r      <= h_act_nxt_s & v_act_nxt_s;
      line_start_r  <= h_wrap_s;
      frame_start_r <= v_wrap_s;
    end
  end

  assign active      = active_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

endmodule
